// File: rtl/vcu128_reset_pkg.sv
// Shared definitions for the VCU128 board reset initiator: sequencer states,
// reset-cause bit positions and a counter sizing helper.
package vcu128_reset_pkg;

  localparam int CAUSE_W      = 5;
  localparam int CAUSE_POR    = 0;
  localparam int CAUSE_BUTTON = 1;
  localparam int CAUSE_SW     = 2;
  localparam int CAUSE_WDT    = 3;
  localparam int CAUSE_LOCK   = 4;

  typedef enum logic [2:0] {
    MMCM_RST  = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vcu128_sync_debounce.sv
// Multi-flop synchronizer for an asynchronous input, optionally followed by a
// debounce filter (DEBOUNCE_BITS=0 gives the plain synchronized level).
module vcu128_sync_debounce #(
  parameter int SYNC_STAGES   = 3,
  parameter int DEBOUNCE_BITS = 0
) (
  input  logic clock,
  input  logic areset,
  input  logic async_in,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_BITS == 0) begin : g_sync_only
      assign level = synced;
    end else begin : g_debounce
      logic [DEBOUNCE_BITS-1:0] db_cnt;
      logic                     db_level;

      // The filtered level resets to 1: the only debounced input is the
      // active-low push-button, whose idle state is released.
      always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
          db_cnt   <= '0;
          db_level <= 1'b1;
        end else if (synced == db_level) begin
          db_cnt <= '0;
        end else if (&db_cnt) begin
          db_level <= synced;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end

      assign level = db_level;
    end
  endgenerate

endmodule

// File: rtl/vcu128_reset_request.sv
// Board reset initiator: sequences MMCM reset, lock wait and reset hold, then
// waits for the last clock domain to leave reset, tracking the reset cause.
module vcu128_reset_request
  import vcu128_reset_pkg::*;
#(
  parameter int SYNC_STAGES       = 3,
  parameter int DEBOUNCE_BITS     = 16,
  parameter int MMCM_RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_BITS = 20,
  parameter int HOLD_CYCLES       = 64
) (
  input  logic               clock,
  input  logic               areset,
  input  logic               button_n,
  input  logic               sw_reset_req,
  input  logic               wdt_expire,
  input  logic               mmcm_locked,
  input  logic               reset_done,
  input  logic               cause_clear,
  output logic               mmcm_reset,
  output logic               sys_areset,
  output logic               busy,
  output logic [CAUSE_W-1:0] reset_cause,
  output logic [3:0]         lock_retries,
  output state_t             debug_state
);

  localparam int MMCM_W = cnt_width(MMCM_RST_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam logic [MMCM_W-1:0]  MMCM_LAST  = MMCM_W'(MMCM_RST_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CAUSE_W-1:0] POR_BIT    = CAUSE_W'(1) << CAUSE_POR;
  localparam logic [CAUSE_W-1:0] LOCK_BIT   = CAUSE_W'(1) << CAUSE_LOCK;

  state_t                       state;
  state_t                       state_nxt;
  logic [CAUSE_W-1:0]           cause_nxt;
  logic [3:0]                   retries_nxt;
  logic [MMCM_W-1:0]            mmcm_cnt;
  logic [LOCK_TIMEOUT_BITS-1:0] lock_cnt;
  logic [HOLD_W-1:0]            hold_cnt;
  logic                         button_db;
  logic                         button_db_q;
  logic                         lock_s;
  logic                         done_s;
  logic                         press;
  logic [CAUSE_W-1:0]           req_cause;
  logic                         any_req;

  vcu128_sync_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_button (
    .clock   (clock),
    .areset  (areset),
    .async_in(button_n),
    .level   (button_db)
  );

  vcu128_sync_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_BITS(0)
  ) u_lock (
    .clock   (clock),
    .areset  (areset),
    .async_in(mmcm_locked),
    .level   (lock_s)
  );

  vcu128_sync_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_BITS(0)
  ) u_done (
    .clock   (clock),
    .areset  (areset),
    .async_in(reset_done),
    .level   (done_s)
  );

  assign press = button_db_q & ~button_db;

  always_comb begin
    req_cause               = '0;
    req_cause[CAUSE_BUTTON] = press;
    req_cause[CAUSE_SW]     = sw_reset_req;
    req_cause[CAUSE_WDT]    = wdt_expire;
  end

  assign any_req = |req_cause;

  // Next-state rules. Lock loss outranks requests wherever both are watched.
  always_comb begin
    state_nxt   = state;
    cause_nxt   = reset_cause;
    retries_nxt = lock_retries;
    case (state)
      MMCM_RST: begin
        cause_nxt = reset_cause | req_cause;
        if (mmcm_cnt == MMCM_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cause_nxt = reset_cause | req_cause;
        if (lock_s) begin
          state_nxt = HOLD;
        end else if (&lock_cnt) begin
          state_nxt = MMCM_RST;
          if (lock_retries != 4'hf) retries_nxt = lock_retries + 4'd1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = MMCM_RST;
          cause_nxt = reset_cause | req_cause | LOCK_BIT;
        end else begin
          cause_nxt = reset_cause | req_cause;
          if (hold_cnt == HOLD_LAST) state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_nxt = MMCM_RST;
          cause_nxt = reset_cause | req_cause | LOCK_BIT;
        end else if (any_req) begin
          state_nxt = HOLD;
          cause_nxt = reset_cause | req_cause;
        end else if (done_s) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = MMCM_RST;
          cause_nxt = req_cause | LOCK_BIT;
        end else if (any_req) begin
          state_nxt = HOLD;
          cause_nxt = req_cause;
        end else if (cause_clear) begin
          cause_nxt = '0;
        end
      end
      default: state_nxt = MMCM_RST;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the transition that causes them.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state        <= MMCM_RST;
      mmcm_reset   <= 1'b1;
      sys_areset   <= 1'b1;
      busy         <= 1'b1;
      reset_cause  <= POR_BIT;
      lock_retries <= '0;
      mmcm_cnt     <= '0;
      lock_cnt     <= '0;
      hold_cnt     <= '0;
      button_db_q  <= 1'b1;
    end else begin
      state        <= state_nxt;
      mmcm_reset   <= (state_nxt == MMCM_RST);
      sys_areset   <= (state_nxt == MMCM_RST) || (state_nxt == WAIT_LOCK) ||
                      (state_nxt == HOLD);
      busy         <= (state_nxt != RUN);
      reset_cause  <= cause_nxt;
      lock_retries <= retries_nxt;
      button_db_q  <= button_db;
      if (state_nxt != state) begin
        mmcm_cnt <= '0;
        lock_cnt <= '0;
        hold_cnt <= '0;
      end else begin
        if (state == MMCM_RST)  mmcm_cnt <= mmcm_cnt + 1'b1;
        if (state == WAIT_LOCK) lock_cnt <= lock_cnt + 1'b1;
        if (state == HOLD)      hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_vcu128_reset_request.sv
// Bench for vcu128_reset_request: directed sequence followed by random
// traffic, every cycle compared against a phase/age reference model.
module tb_vcu128_reset_request;
  import vcu128_reset_pkg::*;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int MR = 4;
  localparam int LT = 5;
  localparam int HC = 8;

  localparam int PH_MRST = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_REL  = 3;
  localparam int PH_RUN  = 4;

  logic         clock;
  logic         areset;
  logic         button_n;
  logic         sw_reset_req;
  logic         wdt_expire;
  logic         mmcm_locked;
  logic         reset_done;
  logic         cause_clear;
  logic         mmcm_reset;
  logic         sys_areset;
  logic         busy;
  logic [4:0]   reset_cause;
  logic [3:0]   lock_retries;
  state_t       debug_state;

  vcu128_reset_request #(
    .SYNC_STAGES      (SS),
    .DEBOUNCE_BITS    (DB),
    .MMCM_RST_CYCLES  (MR),
    .LOCK_TIMEOUT_BITS(LT),
    .HOLD_CYCLES      (HC)
  ) dut (
    .clock       (clock),
    .areset      (areset),
    .button_n    (button_n),
    .sw_reset_req(sw_reset_req),
    .wdt_expire  (wdt_expire),
    .mmcm_locked (mmcm_locked),
    .reset_done  (reset_done),
    .cause_clear (cause_clear),
    .mmcm_reset  (mmcm_reset),
    .sys_areset  (sys_areset),
    .busy        (busy),
    .reset_cause (reset_cause),
    .lock_retries(lock_retries),
    .debug_state (debug_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int          m_ph;
  int          m_age;
  logic [4:0]  m_cause;
  int          m_retries;
  logic [SS-1:0] m_bh, m_lh, m_dh;
  logic        m_deb, m_debq;
  int          m_run;
  int          env_cnt;

  task automatic model_reset();
    m_ph = PH_MRST; m_age = 0; m_cause = 5'b00001; m_retries = 0;
    m_bh = '0; m_lh = '0; m_dh = '0;
    m_deb = 1'b1; m_debq = 1'b1; m_run = 0;
  endtask

  task automatic model_edge();
    logic       lock_ok, done_ok, pressed;
    logic [4:0] rq;
    int         nph;
    lock_ok = m_lh[SS-1];
    done_ok = m_dh[SS-1];
    pressed = m_debq && !m_deb;
    rq  = {1'b0, wdt_expire, sw_reset_req, pressed, 1'b0};
    nph = m_ph;
    if (m_ph == PH_MRST) begin
      m_cause |= rq;
      if (m_age == MR - 1) nph = PH_WAIT;
    end else if (m_ph == PH_WAIT) begin
      m_cause |= rq;
      if (lock_ok) nph = PH_HOLD;
      else if (m_age == (1 << LT) - 1) begin
        nph = PH_MRST;
        if (m_retries < 15) m_retries++;
      end
    end else if (!lock_ok && m_ph != PH_RUN) begin
      nph = PH_MRST;
      m_cause |= rq | 5'b10000;
    end else if (m_ph == PH_HOLD) begin
      m_cause |= rq;
      if (m_age == HC - 1) nph = PH_REL;
    end else if (m_ph == PH_REL) begin
      m_cause |= rq;
      if (rq != 0) nph = PH_HOLD;
      else if (done_ok) nph = PH_RUN;
    end else begin
      if (!lock_ok) begin nph = PH_MRST; m_cause = rq | 5'b10000; end
      else if (rq != 0) begin nph = PH_HOLD; m_cause = rq; end
      else if (cause_clear) m_cause = 5'b0;
    end
    m_age = (nph == m_ph) ? m_age + 1 : 0;
    m_ph  = nph;
    m_debq = m_deb;
    if (m_bh[SS-1] == m_deb) m_run = 0;
    else begin
      m_run++;
      if (m_run == (1 << DB)) begin m_deb = m_bh[SS-1]; m_run = 0; end
    end
    m_bh = {m_bh[SS-2:0], button_n};
    m_lh = {m_lh[SS-2:0], mmcm_locked};
    m_dh = {m_dh[SS-2:0], reset_done};
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic compare_all();
    check("mmcm_reset",   {31'd0, mmcm_reset}, {31'd0, m_ph == PH_MRST});
    check("sys_areset",   {31'd0, sys_areset}, {31'd0, m_ph <= PH_HOLD});
    check("busy",         {31'd0, busy},       {31'd0, m_ph != PH_RUN});
    check("reset_cause",  {27'd0, reset_cause}, {27'd0, m_cause});
    check("lock_retries", {28'd0, lock_retries}, m_retries);
    check("debug_state_run", {31'd0, debug_state == RUN}, {31'd0, m_ph == PH_RUN});
  endtask

  // Downstream chain stand-in: reset_done follows sys_areset, rising 3 cycles late.
  task automatic tick();
    @(posedge clock);
    if (areset) model_reset(); else model_edge();
    #1;
    compare_all();
    if (m_ph <= PH_HOLD) env_cnt = 0;
    else if (env_cnt < 3) env_cnt++;
    reset_done = (env_cnt >= 3);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin tick(); n++; end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_areset();
    areset = 1'b1;
    model_reset();
    #1;
    compare_all();
    tick();
    areset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lock_off;
    areset = 1'b1; button_n = 1'b1; sw_reset_req = 1'b0; wdt_expire = 1'b0;
    mmcm_locked = 1'b1; reset_done = 1'b0; cause_clear = 1'b0;
    env_cnt = 0; lock_off = 0;
    model_reset();
    #2;
    check("por_mmcm_reset", {31'd0, mmcm_reset}, 32'd1);
    check("por_sys_areset", {31'd0, sys_areset}, 32'd1);
    check("por_busy",       {31'd0, busy},       32'd1);
    check("por_cause",      {27'd0, reset_cause}, 32'h01);
    check("por_retries",    {28'd0, lock_retries}, 32'd0);
    ticks(2);
    areset = 1'b0;

    // power-on sequence
    wait_idle(100, "poweron_timeout");
    check("poweron_cause", {27'd0, reset_cause}, 32'h01);
    ticks(5);

    // software request, then cause clear
    sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
    check("sw_sys_rise", {31'd0, sys_areset}, 32'd1);
    check("sw_mmcm_low", {31'd0, mmcm_reset}, 32'd0);
    wait_idle(100, "sw_timeout");
    check("sw_cause", {27'd0, reset_cause}, 32'h04);
    cause_clear = 1'b1; tick(); cause_clear = 1'b0;
    check("clear_cause", {27'd0, reset_cause}, 32'h00);

    // button glitch, then a real press
    button_n = 1'b0; ticks(10); button_n = 1'b1; ticks(30);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    button_n = 1'b0; ticks(20); button_n = 1'b1;
    check("press_sys", {31'd0, sys_areset}, 32'd1);
    wait_idle(200, "press_timeout");
    check("press_cause", {27'd0, reset_cause}, 32'h02);

    // lock loss with repeated lock timeouts
    mmcm_locked = 1'b0;
    begin
      int n = 0;
      while (lock_retries !== 4'd2 && n < 300) begin tick(); n++; end
    end
    check("retries_two", {28'd0, lock_retries}, 32'd2);
    mmcm_locked = 1'b1;
    wait_idle(200, "relock_timeout");
    check("relock_cause", {27'd0, reset_cause}, 32'h10);

    // lock loss and watchdog in the same cycle
    mmcm_locked = 1'b0; ticks(2);
    wdt_expire = 1'b1; tick(); wdt_expire = 1'b0;
    check("wdt_lock_mmcm", {31'd0, mmcm_reset}, 32'd1);
    check("wdt_lock_cause", {27'd0, reset_cause}, 32'h18);
    mmcm_locked = 1'b1;
    wait_idle(200, "wdt_lock_timeout");
    check("wdt_lock_retries", {28'd0, lock_retries}, 32'd2);

    // areset during HOLD
    sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0; ticks(3);
    pulse_areset();
    check("mid_retries", {28'd0, lock_retries}, 32'd0);
    check("mid_cause",   {27'd0, reset_cause}, 32'h01);
    wait_idle(200, "mid_timeout");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      sw_reset_req = ($urandom_range(0, 39) == 0);
      wdt_expire   = ($urandom_range(0, 59) == 0);
      cause_clear  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) button_n = ~button_n;
      if (lock_off > 0) begin
        lock_off--;
        mmcm_locked = (lock_off == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        lock_off = $urandom_range(1, 60);
        mmcm_locked = 1'b0;
      end
      if ($urandom_range(0, 799) == 0) pulse_areset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
